// File: rtl/nn_pkg.sv
// nn_pkg: shared FSM state type and frame-size helper for nn_infer_ctrl
package nn_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, PUSH, NNRST, RUN, HOLD} state_e;

    function automatic int frame_bits(input int num_inputs, input int data_width);
        return num_inputs * data_width;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchroniser with rising-edge detect on the synchronised level
module sync_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[1:0], async_in};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/nn_infer_ctrl.sv
// nn_infer_ctrl: serial frame loader and NN run sequencer; define NN_TIMEOUT_EN for the run watchdog
module nn_infer_ctrl
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS     = 784,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        serial_clk,
    output logic        push_buffer,
    output logic        nn_reset,
    output logic        nn_valid,
    input  logic        nn_out_valid,
    input  logic [3:0]  max_index,
    input  logic [15:0] max_value,
    output logic [3:0]  result_index,
    output logic [15:0] result_value,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  frame_count
);

    localparam int FB = frame_bits(NUM_INPUTS, DATA_WIDTH);
    localparam int CW = $clog2(FB + 1);
    localparam logic [CW-1:0] FULL = CW'(FB);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    result_index_q, result_index_d;
    logic [15:0]   result_value_q, result_value_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          result_valid_q, result_valid_d;
    logic          push_buffer_q, push_buffer_d;
    logic          nn_reset_q, nn_reset_d;
    logic          nn_valid_q, nn_valid_d;
    logic          busy_q, busy_d;
    logic          rise, expire;

    sync_edge_det u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (serial_clk),
        .rise     (rise)
    );

`ifdef NN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          timeout_err_q, timeout_err_d;

    always_comb begin
        tmr_d         = (state_q == RUN) ? tmr_q + 1'b1 : '0;
        expire        = state_q == RUN && !nn_out_valid && tmr_q == TW'(TIMEOUT_CYCLES - 1);
        timeout_err_d = timeout_err_q | expire;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmr_q         <= tmr_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Edges keep counting in every state so the next frame can stream in while the NN runs
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + CW'(rise && cnt_q != FULL);
        result_index_d = result_index_q;
        result_value_d = result_value_q;
        result_valid_d = result_valid_q;
        frame_count_d  = frame_count_q;
        case (state_q)
            IDLE:  state_d = (cnt_d != '0) ? LOAD : IDLE;
            LOAD: if (cnt_q == FULL) begin
                state_d = PUSH;
                cnt_d   = CW'(rise);
            end
            PUSH:  state_d = NNRST;
            NNRST: state_d = RUN;
            RUN: if (nn_out_valid) begin
                result_index_d = max_index;
                result_value_d = max_value;
                result_valid_d = 1'b1;
                frame_count_d  = frame_count_q + 8'd1;
                state_d        = HOLD;
            end else if (expire) begin
                state_d = IDLE;
            end
            HOLD: if (result_ready) begin
                result_valid_d = 1'b0;
                state_d        = (cnt_d != '0) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        push_buffer_d = state_d == PUSH;
        nn_reset_d    = state_d == PUSH || state_d == NNRST || expire;
        nn_valid_d    = state_d == RUN;
        busy_d        = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            result_index_q <= '0;
            result_value_q <= '0;
            result_valid_q <= 1'b0;
            frame_count_q  <= '0;
            push_buffer_q  <= 1'b0;
            nn_reset_q     <= 1'b1;
            nn_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_index_q <= result_index_d;
            result_value_q <= result_value_d;
            result_valid_q <= result_valid_d;
            frame_count_q  <= frame_count_d;
            push_buffer_q  <= push_buffer_d;
            nn_reset_q     <= nn_reset_d;
            nn_valid_q     <= nn_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign push_buffer  = push_buffer_q;
    assign nn_reset     = nn_reset_q;
    assign nn_valid     = nn_valid_q;
    assign busy         = busy_q;
    assign result_index = result_index_q;
    assign result_value = result_value_q;
    assign result_valid = result_valid_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// tb_nn_infer_ctrl: randomized serial/NN stimulus with a result scoreboard and frame-level reference model
module tb_nn_infer_ctrl;

    localparam int NI = 4;
    localparam int DW = 4;
    localparam int FB = NI * DW;
    localparam int TO = 100;

    logic        clk, resetn, serial_clk, nn_out_valid, result_ready;
    logic [3:0]  max_index;
    logic [15:0] max_value;
    logic        push_buffer, nn_reset, nn_valid, result_valid, busy, timeout_err;
    logic [3:0]  result_index;
    logic [15:0] result_value;
    logic [7:0]  frame_count;

    int          checks = 0, failures = 0, push_cnt = 0, edges_req = 0, edges_done = 0;
    logic [7:0]  fc_model = 0;
    logic [27:0] exp_q[$];

    nn_infer_ctrl #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .serial_clk   (serial_clk),
        .push_buffer  (push_buffer),
        .nn_reset     (nn_reset),
        .nn_valid     (nn_valid),
        .nn_out_valid (nn_out_valid),
        .max_index    (max_index),
        .max_value    (max_value),
        .result_index (result_index),
        .result_value (result_value),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .frame_count  (frame_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Host serial clock: one rising edge per requested bit, random high/low widths
    initial begin
        serial_clk = 0;
        forever begin
            @(posedge clk);
            if (edges_done < edges_req) begin
                #1 serial_clk = 1;
                repeat ($urandom_range(2, 3)) @(posedge clk);
                #1 serial_clk = 0;
                repeat ($urandom_range(2, 3)) @(posedge clk);
                edges_done++;
            end
        end
    end

    // Every push must be a single pulse followed by exactly two cycles of NN reset, then run
    initial forever begin
        @(negedge clk);
        if (resetn && push_buffer) begin
            push_cnt++;
            chk("push_nnrst_a", nn_reset, 1);
            @(negedge clk);
            chk("push_single", push_buffer, 0);
            chk("push_nnrst_b", nn_reset, 1);
            @(negedge clk);
            chk("nnrst_len", nn_reset, 0);
            chk("run_valid", nn_valid, 1);
        end
    end

    // Scoreboard monitor: results are popped on handshake and must stay stable until then
    initial begin
        logic        pv, ph;
        logic [27:0] prev, e;
        pv = 0; ph = 0; prev = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pv = 0; ph = 0;
            end else begin
                if (pv && !ph) begin
                    chk("hold_valid", result_valid, 1);
                    chk("hold_stable", {result_index, result_value, frame_count}, prev);
                end
                ph = result_valid && result_ready;
                if (ph) begin
                    if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_result", {result_index, result_value, frame_count}, e);
                    end
                end
                pv   = result_valid;
                prev = {result_index, result_value, frame_count};
            end
        end
    end

    task automatic wait_for(input int w, input string name);
        int n = 0;
        while (((w == 0) ? nn_valid : result_valid) !== 1'b1 && n < 3000) begin
            cyc();
            n++;
        end
        chk(name, (w == 0) ? nn_valid : result_valid, 1);
    endtask

    task automatic send(input int n);
        int k = 0;
        edges_req += n;
        while (edges_done != edges_req && k < 20 * n + 100) begin
            cyc();
            k++;
        end
        chk("send_done", edges_done, edges_req);
        repeat (4) cyc();
    endtask

    task automatic respond(input logic [3:0] i, input logic [15:0] v);
        nn_out_valid = 1; max_index = i; max_value = v;
        fc_model++;
        exp_q.push_back({i, v, fc_model});
        cyc();
        nn_out_valid = 0;
    endtask

    task automatic handshake();
        result_ready = 1;
        cyc();
        result_ready = 0;
        chk("rv_cleared", result_valid, 0);
    endtask

    task automatic stray(input string name);
        nn_out_valid = 1; max_index = 4'($urandom); max_value = 16'($urandom);
        cyc();
        nn_out_valid = 0;
        repeat (3) cyc();
        chk({name, "_rv"}, result_valid, 0);
        chk({name, "_fc"}, frame_count, fc_model);
    endtask

    initial begin
        int pc0;
        resetn = 0; nn_out_valid = 0; result_ready = 0; max_index = 0; max_value = 0;
        repeat (3) cyc();
        chk("rst_push", push_buffer, 0);
        chk("rst_nnrst", nn_reset, 1);
        chk("rst_nnvalid", nn_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_res", {result_index, result_value}, 0);
        resetn = 1;
        cyc();
        chk("rel_nnrst", nn_reset, 0);
        stray("stray_idle");
        chk("idle_busy", busy, 0);
        send(5);
        chk("load_busy", busy, 1);
        stray("stray_load");
        chk("load_nopush", push_cnt, 0);
        send(FB - 5);
        wait_for(0, "run_a");
        chk("push_a", push_cnt, 1);
        repeat (50) cyc();
        respond(4'd7, 16'h0340);
        wait_for(1, "rv_a");
        chk("res_a", {result_index, result_value, frame_count}, {4'd7, 16'h0340, 8'd1});
        repeat (100) cyc();
        handshake();
        chk("hs_idle", busy, 0);
        send(10);
        chk("mid_busy", busy, 1);
        resetn = 0;
        cyc();
        resetn = 1;
        fc_model = 0;
        cyc();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fc", frame_count, 0);
        pc0 = push_cnt;
        send(FB - 1);
        chk("fresh_nopush", push_cnt, pc0);
        chk("fresh_busy", busy, 1);
        send(1);
        wait_for(0, "run_b");
        chk("fresh_push", push_cnt, pc0 + 1);
        respond(4'($urandom), 16'($urandom));
        wait_for(1, "rv_b");
        handshake();
        edges_req += FB * 255;
        for (int f = 0; f < 255; f++) begin
            wait_for(0, "run_loop");
            repeat ($urandom_range(0, 19)) cyc();
            respond(4'($urandom), 16'($urandom));
            wait_for(1, "rv_loop");
            chk("fc_loop", frame_count, fc_model);
            repeat ($urandom_range(0, 10)) begin
                nn_out_valid = 1'($urandom);
                max_index = 4'($urandom);
                cyc();
            end
            nn_out_valid = 0;
            handshake();
        end
        chk("fc_wrap", frame_count, 0);
        for (int k = 0; k < 5000 && edges_done != edges_req; k++) cyc();
        repeat (10) cyc();
        chk("edges_all", edges_done, edges_req);
        chk("push_total", push_cnt, 257);
        chk("end_busy", busy, 0);
        chk("sb_drained", exp_q.size(), 0);
`ifdef NN_TIMEOUT_EN
        send(FB);
        wait_for(0, "run_to");
        repeat (TO - 1) cyc();
        chk("to_early", timeout_err, 0);
        chk("to_running", nn_valid, 1);
        cyc();
        chk("to_err", timeout_err, 1);
        chk("to_nnrst", nn_reset, 1);
        chk("to_idle", busy, 0);
        chk("to_rv", result_valid, 0);
        cyc();
        chk("to_pulse", nn_reset, 0);
        chk("to_sticky", timeout_err, 1);
        chk("to_fc", frame_count, fc_model);
`else
        chk("no_terr", timeout_err, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_infer_ctrl.md
NN_INFER_CTRL -- requirements
Module: nn_infer_ctrl

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 784, meaning pixels per frame.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning bits per pixel.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the run watchdog limit in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port serial_clk  input  1  asynchronous serial bit clock from the external host.
REQ-007 SHALL have port push_buffer  output  1  one-cycle pulse that moves the shift register contents to the NN input.
REQ-008 SHALL have port nn_reset  output  1  active-high synchronous reset to the neural network.
REQ-009 SHALL have port nn_valid  output  1  NN input-valid (run enable).
REQ-010 SHALL have port nn_out_valid  input  1  NN completion flag.
REQ-011 SHALL have ports max_index  input  4  and  max_value  input  16, the NN argmax result.
REQ-012 SHALL have ports result_index  output  4  and  result_value  output  16, the latched result.
REQ-013 SHALL have ports result_valid  output  1  and  result_ready  input  1, the result handshake.
REQ-014 SHALL have ports busy  output  1,  timeout_err  output  1  (sticky) and  frame_count  output  8.

Function
REQ-015 SHALL synchronise serial_clk through two flops and detect rising edges on the synchronised signal.
REQ-016 SHALL count detected edges in a bit counter of width clog2(NUM_INPUTS*DATA_WIDTH+1).
REQ-017 SHALL implement the states IDLE, LOAD, PUSH, NNRST, RUN, HOLD.
REQ-018 SHALL go IDLE->LOAD on the first detected edge, with that edge counted as bit 1.
REQ-019 SHALL go LOAD->PUSH in the cycle after the bit count reaches NUM_INPUTS*DATA_WIDTH, then clear the counter.
REQ-020 SHALL assert push_buffer for exactly the one cycle spent in PUSH.
REQ-021 SHALL assert nn_reset in PUSH and NNRST, holding the NN in reset for 2 cycles.
REQ-022 SHALL hold nn_valid high throughout RUN and low in every other state.
REQ-023 SHALL, on nn_out_valid in RUN, latch max_index and max_value next cycle, set result_valid, increment frame_count (wrapping 255->0) and go to HOLD.
REQ-024 SHALL hold result_index, result_value and result_valid stable until result_valid and result_ready are both high, then clear result_valid and go to IDLE.
REQ-025 SHALL count serial edges arriving in PUSH/NNRST/RUN/HOLD toward the next frame, with no edge dropped.
REQ-026 SHALL, on reaching HOLD with the next frame's bit count already at or above 1, go to LOAD after the handshake instead of IDLE.
REQ-027 SHALL ignore nn_out_valid outside RUN.
REQ-028 SHALL drive busy high in every state except IDLE.

Reset
REQ-029 SHALL, on resetn low, asynchronously enter IDLE.
REQ-030 SHALL, on resetn low, clear counters, synchroniser flops, result registers, result_valid, timeout_err and frame_count.
REQ-031 SHALL, on resetn low, drive nn_reset=1 and push_buffer=0, nn_valid=0.
REQ-032 SHALL, when reset occurs mid-frame, discard the partial bit count.

Configuration
REQ-033 SHALL, with NN_TIMEOUT_EN defined, count cycles in RUN.
REQ-034 SHALL, with NN_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES without nn_out_valid, set timeout_err (sticky until reset), pulse nn_reset for one cycle and return to IDLE with no result latched.
REQ-035 SHALL, without NN_TIMEOUT_EN, wait in RUN indefinitely, tie timeout_err to 0 and include no watchdog counter.

Structure
REQ-036 SHALL place the state enum type and the FRAME_BITS constant computation in the shared package nn_pkg.
REQ-037 SHALL place the 2-flop synchroniser plus edge detector in the sub-module sync_edge_det.

Verification
REQ-038 SHALL check: 12544 serial edges then nn_out_valid after 50 cycles with max_index=7, max_value=16'h0340 -> one push_buffer pulse, nn_reset held 2 cycles, result_index=7, result_value=16'h0340, result_valid=1, frame_count=1.
REQ-039 SHALL check: result_ready held low for 100 cycles, then raised for 1 cycle -> outputs stable throughout, result_valid drops the next cycle, state returns to IDLE.
REQ-040 SHALL check: resetn asserted after 5000 edges, then 12544 fresh edges -> exactly one push occurs, after edge 12544 of the fresh frame.
REQ-041 SHALL check: nn_out_valid pulsed in IDLE and in LOAD -> no result latched, frame_count unchanged.
REQ-042 SHALL check, with NN_TIMEOUT_EN and TIMEOUT_CYCLES=100: NN never completes -> timeout_err=1 at cycle 100 of RUN, one nn_reset pulse, IDLE, result_valid=0.
REQ-043 SHALL check: 256 back-to-back frames with next-frame edges arriving during HOLD -> frame_count wraps to 0 and no edge is lost.
